// File: rtl/uart_pkg.sv
// Shared UART types: TX/RX state encodings, latched TX frame config and the parity helper.
// Pure definitions; no state, no flow control.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int MAX_DATA_BITS  = 9;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  typedef struct packed {
    logic parity_en;
    logic two_stop;
  } tx_cfg_t;

  // Data is zero-extended by the caller, so the extra bits never change the result.
  function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: os_tick pulses for one cycle every max(baud_div,1) cycles.
// A new divisor is picked up at the next wrap; free-running, never stalls.
module uart_baud_gen #(
  parameter int DIV_W = 16
) (
  input  logic             main_clock,
  input  logic             reset_all,
  input  logic [DIV_W-1:0] baud_div,
  output logic             os_tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_q;  // divisor for the current period, never zero

  assign os_tick = (cnt == div_q - DIV_W'(1));

  always_ff @(posedge main_clock or posedge reset_all) begin
    if (reset_all) begin
      cnt   <= '0;
      div_q <= DIV_W'(1);
    end else if (os_tick) begin
      cnt   <= '0;
      div_q <= (baud_div == '0) ? DIV_W'(1) : baud_div;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_core.sv
// UART core: oversampled TX and RX sharing one baud generator, with parity, 1/2 stop bits and loopback.
// RX input sees a 2-cycle synchroniser; no backpressure -- tx_start is dropped while tx_busy.
module uart_core
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int DIV_W      = 16,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                 main_clock,
  input  logic                 reset_all,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 two_stop,
  input  logic                 loopback,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_start,
  output logic                 tx_serial,
  output logic                 tx_busy,
  output logic                 tx_done,
  input  logic                 rx_serial,
  output logic                 rx_busy,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err
);

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam int BC_W = 4;
  localparam logic [OS_W-1:0] OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_MID   = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BC_W-1:0] BIT_LAST = BC_W'(DATA_BITS - 1);

  logic os_tick;

  uart_baud_gen #(.DIV_W(DIV_W)) u_baud_gen (
    .main_clock (main_clock),
    .reset_all  (reset_all),
    .baud_div   (baud_div),
    .os_tick    (os_tick)
  );

  // ---------------------------------------------------------------- TX
  tx_state_t            tx_state, tx_state_nx;
  logic                 tx_armed, tx_armed_nx;
  logic [OS_W-1:0]      tx_os_cnt, tx_os_cnt_nx;
  logic [BC_W-1:0]      tx_bit_cnt, tx_bit_cnt_nx;
  logic [DATA_BITS-1:0] tx_shift, tx_shift_nx;
  logic                 tx_par, tx_par_nx;
  tx_cfg_t              tx_cfg, tx_cfg_nx;
  logic                 tx_serial_nx, tx_done_nx, tx_bit_end;

  // The OS counter is a power-of-two width, so it wraps back to 0 on its own at bit end.
  assign tx_bit_end = tx_armed && os_tick && (tx_os_cnt == OS_LAST);
  assign tx_busy    = (tx_state != TX_IDLE);

  always_ff @(posedge main_clock or posedge reset_all) begin
    if (reset_all) begin
      tx_state   <= TX_IDLE;
      tx_armed   <= 1'b0;
      tx_os_cnt  <= '0;
      tx_bit_cnt <= '0;
      tx_shift   <= '0;
      tx_par     <= 1'b0;
      tx_cfg     <= '0;
      tx_serial  <= 1'b1;
      tx_done    <= 1'b0;
    end else begin
      tx_state   <= tx_state_nx;
      tx_armed   <= tx_armed_nx;
      tx_os_cnt  <= tx_os_cnt_nx;
      tx_bit_cnt <= tx_bit_cnt_nx;
      tx_shift   <= tx_shift_nx;
      tx_par     <= tx_par_nx;
      tx_cfg     <= tx_cfg_nx;
      tx_serial  <= tx_serial_nx;
      tx_done    <= tx_done_nx;
    end
  end

  always_comb begin
    tx_state_nx   = tx_state;
    tx_armed_nx   = tx_armed;
    tx_os_cnt_nx  = tx_os_cnt;
    tx_bit_cnt_nx = tx_bit_cnt;
    tx_shift_nx   = tx_shift;
    tx_par_nx     = tx_par;
    tx_cfg_nx     = tx_cfg;
    tx_done_nx    = 1'b0;
    tx_serial_nx  = 1'b1;

    if (tx_armed && os_tick) tx_os_cnt_nx = tx_os_cnt + 1'b1;

    unique case (tx_state)
      TX_IDLE: begin
        // The tx_done cycle still belongs to the finished frame.
        if (tx_start && !tx_done) begin
          tx_state_nx        = TX_START;
          tx_armed_nx        = 1'b0;
          tx_os_cnt_nx       = '0;
          tx_bit_cnt_nx      = '0;
          tx_shift_nx        = tx_data;
          tx_par_nx          = calc_parity(MAX_DATA_BITS'(tx_data), parity_odd);
          tx_cfg_nx.parity_en = parity_en;
          tx_cfg_nx.two_stop  = two_stop;
        end
      end
      TX_START: begin
        // Start bit is aligned to the first oversample tick after acceptance.
        if (!tx_armed) begin
          if (os_tick) tx_armed_nx = 1'b1;
        end else if (tx_bit_end) begin
          tx_state_nx = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_bit_end) begin
          tx_shift_nx   = tx_shift >> 1;
          tx_bit_cnt_nx = tx_bit_cnt + 1'b1;
          if (tx_bit_cnt == BIT_LAST) begin
            tx_bit_cnt_nx = '0;
            tx_state_nx   = tx_cfg.parity_en ? TX_PARITY : TX_STOP;
          end
        end
      end
      TX_PARITY: begin
        if (tx_bit_end) tx_state_nx = TX_STOP;
      end
      TX_STOP: begin
        if (tx_bit_end) begin
          if (tx_cfg.two_stop && (tx_bit_cnt == '0)) begin
            tx_bit_cnt_nx = BC_W'(1);
          end else begin
            tx_state_nx = TX_IDLE;
            tx_armed_nx = 1'b0;
            tx_done_nx  = 1'b1;
          end
        end
      end
      default: tx_state_nx = TX_IDLE;
    endcase

    unique case (tx_state_nx)
      TX_START:  tx_serial_nx = !tx_armed_nx;
      TX_DATA:   tx_serial_nx = tx_shift_nx[0];
      TX_PARITY: tx_serial_nx = tx_par_nx;
      default:   tx_serial_nx = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------- RX
  logic                 rx_in, rx_meta, rx_sync;
  rx_state_t            rx_state, rx_state_nx;
  logic [OS_W-1:0]      rx_os_cnt, rx_os_cnt_nx;
  logic [BC_W-1:0]      rx_bit_cnt, rx_bit_cnt_nx;
  logic [DATA_BITS-1:0] rx_shift, rx_shift_nx, rx_data_nx;
  logic                 rx_par_bit, rx_par_bit_nx;
  logic                 rx_done_nx, rx_pe_nx, rx_fe_nx, rx_sample;

  assign rx_in     = loopback ? tx_serial : rx_serial;
  assign rx_sample = os_tick && (rx_os_cnt == OS_LAST);
  assign rx_busy   = (rx_state != RX_IDLE);

  always_ff @(posedge main_clock or posedge reset_all) begin
    if (reset_all) begin
      rx_meta       <= 1'b1;
      rx_sync       <= 1'b1;
      rx_state      <= RX_IDLE;
      rx_os_cnt     <= '0;
      rx_bit_cnt    <= '0;
      rx_shift      <= '0;
      rx_par_bit    <= 1'b0;
      rx_data       <= '0;
      rx_done       <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      rx_meta       <= rx_in;
      rx_sync       <= rx_meta;
      rx_state      <= rx_state_nx;
      rx_os_cnt     <= rx_os_cnt_nx;
      rx_bit_cnt    <= rx_bit_cnt_nx;
      rx_shift      <= rx_shift_nx;
      rx_par_bit    <= rx_par_bit_nx;
      rx_data       <= rx_data_nx;
      rx_done       <= rx_done_nx;
      rx_parity_err <= rx_pe_nx;
      rx_frame_err  <= rx_fe_nx;
    end
  end

  always_comb begin
    rx_state_nx   = rx_state;
    rx_os_cnt_nx  = rx_os_cnt;
    rx_bit_cnt_nx = rx_bit_cnt;
    rx_shift_nx   = rx_shift;
    rx_par_bit_nx = rx_par_bit;
    rx_data_nx    = rx_data;
    rx_pe_nx      = rx_parity_err;
    rx_fe_nx      = rx_frame_err;
    rx_done_nx    = 1'b0;

    if (os_tick) rx_os_cnt_nx = rx_os_cnt + 1'b1;

    unique case (rx_state)
      RX_IDLE: begin
        rx_os_cnt_nx = '0;
        if (os_tick && !rx_sync) rx_state_nx = RX_START;
      end
      RX_START: begin
        // Half a bit after detection: still low means a real start bit.
        if (os_tick && (rx_os_cnt == OS_MID)) begin
          rx_os_cnt_nx  = '0;
          rx_bit_cnt_nx = '0;
          rx_state_nx   = rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_sample) begin
          rx_shift_nx   = {rx_sync, rx_shift[DATA_BITS-1:1]};
          rx_bit_cnt_nx = rx_bit_cnt + 1'b1;
          if (rx_bit_cnt == BIT_LAST) rx_state_nx = parity_en ? RX_PARITY : RX_STOP;
        end
      end
      RX_PARITY: begin
        if (rx_sample) begin
          rx_par_bit_nx = rx_sync;
          rx_state_nx   = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_sample) begin
          rx_state_nx = RX_IDLE;
          rx_done_nx  = 1'b1;
          rx_data_nx  = rx_shift;
          rx_pe_nx    = parity_en &&
                        (rx_par_bit != calc_parity(MAX_DATA_BITS'(rx_shift), parity_odd));
          rx_fe_nx    = !rx_sync;
        end
      end
      default: rx_state_nx = RX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core: loopback frames, parity/frame errors, glitch rejection, handshakes, reset.
`timescale 1ns/1ps
module tb_uart_core;

  logic        main_clock = 1'b0;
  logic        reset_all  = 1'b1;
  logic [15:0] baud_div;
  logic        parity_en, parity_odd, two_stop, loopback;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_serial, tx_busy, tx_done;
  logic        rx_serial;
  logic        rx_busy;
  logic [7:0]  rx_data;
  logic        rx_done, rx_parity_err, rx_frame_err;

  int tests  = 0;
  int failed = 0;

  uart_core #(.DATA_BITS(8), .DIV_W(16), .OVERSAMPLE(16)) dut (
    .main_clock    (main_clock),
    .reset_all     (reset_all),
    .baud_div      (baud_div),
    .parity_en     (parity_en),
    .parity_odd    (parity_odd),
    .two_stop      (two_stop),
    .loopback      (loopback),
    .tx_data       (tx_data),
    .tx_start      (tx_start),
    .tx_serial     (tx_serial),
    .tx_busy       (tx_busy),
    .tx_done       (tx_done),
    .rx_serial     (rx_serial),
    .rx_busy       (rx_busy),
    .rx_data       (rx_data),
    .rx_done       (rx_done),
    .rx_parity_err (rx_parity_err),
    .rx_frame_err  (rx_frame_err)
  );

  always #5 main_clock = ~main_clock;

  // Event monitor: counts done pulses and rx_busy rises, captures the RX result.
  int         rx_cnt = 0;
  int         tx_cnt = 0;
  int         busy_rises = 0;
  logic       busy_prev = 1'b0;
  logic [7:0] cap_data = 8'h00;
  logic       cap_pe = 1'b0;
  logic       cap_fe = 1'b0;

  always @(negedge main_clock) begin
    if (!reset_all) begin
      if (rx_done) begin
        rx_cnt++;
        cap_data = rx_data;
        cap_pe   = rx_parity_err;
        cap_fe   = rx_frame_err;
      end
      if (tx_done) tx_cnt++;
      if (rx_busy && !busy_prev) busy_rises++;
    end
    busy_prev = rx_busy;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed no finish, expected finish before 2ms");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge main_clock);
  endtask

  task automatic start_tx(input logic [7:0] d);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge main_clock);
    tx_start = 1'b0;
  endtask

  // Waits for the start-bit fall, then samples 12 mid-bit slots of 64 cycles each.
  task automatic capture_tx(input int poke_off, output logic [11:0] bits,
                            output int done_off, output int start_len);
    bit got = 1'b0;
    bits      = '1;
    done_off  = -1;
    start_len = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge main_clock);
      if (!tx_serial) begin
        got = 1'b1;
        break;
      end
    end
    check("tx_start_bit_seen", 32'(got), 32'd1);
    if (got) begin
      for (int off = 0; off < 768; off++) begin
        if (off == poke_off) begin
          tx_data  = 8'hFF;
          tx_start = 1'b1;
        end else begin
          tx_start = 1'b0;
        end
        if (off % 64 == 32) bits[off / 64] = tx_serial;
        if (off < 96 && !tx_serial) start_len++;
        if (tx_done && done_off < 0) done_off = off;
        @(negedge main_clock);
      end
      tx_start = 1'b0;
    end
  endtask

  task automatic drive_rx(input logic [11:0] bits, input int nslots);
    for (int k = 0; k < nslots; k++) begin
      rx_serial = bits[k];
      idle(64);
    end
    rx_serial = 1'b1;
    idle(160);
  endtask

  initial begin
    logic [11:0] bits;
    int doff, slen, rc, tc, br;

    baud_div   = 16'd4;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    two_stop   = 1'b0;
    loopback   = 1'b1;
    tx_data    = 8'h00;
    tx_start   = 1'b0;
    rx_serial  = 1'b1;
    idle(3);

    check("rst_tx_serial", 32'(tx_serial), 32'd1);
    check("rst_tx_busy", 32'(tx_busy), 32'd0);
    check("rst_tx_done", 32'(tx_done), 32'd0);
    check("rst_rx_busy", 32'(rx_busy), 32'd0);
    check("rst_rx_done", 32'(rx_done), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_rx_pe", 32'(rx_parity_err), 32'd0);
    check("rst_rx_fe", 32'(rx_frame_err), 32'd0);
    reset_all = 1'b0;
    idle(20);

    // 8N1 loopback 0xA5: start + 1,0,1,0,0,1,0,1 + stop -> 12'hF4A
    rc = rx_cnt;
    start_tx(8'hA5);
    check("a5_busy_after_start", 32'(tx_busy), 32'd1);
    capture_tx(-1, bits, doff, slen);
    check("a5_frame", 32'(bits), 32'hF4A);
    check("a5_start_len", 32'(slen), 32'd64);
    check("a5_done_off", 32'(doff), 32'd640);
    check("a5_rx_count", 32'(rx_cnt - rc), 32'd1);
    check("a5_rx_data", 32'(cap_data), 32'hA5);
    check("a5_rx_pe", 32'(cap_pe), 32'd0);
    check("a5_rx_fe", 32'(cap_fe), 32'd0);

    // Even parity 0x07: three ones -> parity bit 1
    parity_en = 1'b1;
    parity_odd = 1'b0;
    rc = rx_cnt;
    start_tx(8'h07);
    capture_tx(-1, bits, doff, slen);
    check("e07_frame", 32'(bits), 32'hE0E);
    check("e07_parity_bit", 32'(bits[9]), 32'd1);
    check("e07_done_off", 32'(doff), 32'd704);
    check("e07_rx_count", 32'(rx_cnt - rc), 32'd1);
    check("e07_rx_data", 32'(cap_data), 32'h07);
    check("e07_rx_pe", 32'(cap_pe), 32'd0);

    // Odd parity 0x07 -> parity bit 0
    parity_odd = 1'b1;
    rc = rx_cnt;
    start_tx(8'h07);
    capture_tx(-1, bits, doff, slen);
    check("o07_frame", 32'(bits), 32'hC0E);
    check("o07_parity_bit", 32'(bits[9]), 32'd0);
    check("o07_rx_data", 32'(cap_data), 32'h07);
    check("o07_rx_pe", 32'(cap_pe), 32'd0);

    // External 0x07, even parity, parity bit forced to 0
    loopback = 1'b0;
    parity_odd = 1'b0;
    rc = rx_cnt;
    drive_rx(12'h40E, 11);
    check("bad_par_rx_count", 32'(rx_cnt - rc), 32'd1);
    check("bad_par_rx_data", 32'(cap_data), 32'h07);
    check("bad_par_rx_pe", 32'(cap_pe), 32'd1);
    check("bad_par_rx_fe", 32'(cap_fe), 32'd0);
    check("bad_par_pe_held", 32'(rx_parity_err), 32'd1);

    // External 0x3C 8N1 with a low stop bit, then a good frame
    parity_en = 1'b0;
    rc = rx_cnt;
    drive_rx(12'h078, 10);
    check("ferr_rx_count", 32'(rx_cnt - rc), 32'd1);
    check("ferr_rx_data", 32'(cap_data), 32'h3C);
    check("ferr_rx_fe", 32'(cap_fe), 32'd1);
    check("ferr_fe_held", 32'(rx_frame_err), 32'd1);
    rc = rx_cnt;
    drive_rx(12'h278, 10);
    check("fgood_rx_count", 32'(rx_cnt - rc), 32'd1);
    check("fgood_rx_data", 32'(cap_data), 32'h3C);
    check("fgood_rx_fe", 32'(rx_frame_err), 32'd0);
    check("fgood_rx_pe", 32'(rx_parity_err), 32'd0);

    // 16-cycle low glitch: 4 ticks, shorter than half a bit
    rc = rx_cnt;
    br = busy_rises;
    rx_serial = 1'b0;
    idle(16);
    rx_serial = 1'b1;
    idle(200);
    check("glitch_busy_rose", 32'(busy_rises - br), 32'd1);
    check("glitch_busy_now", 32'(rx_busy), 32'd0);
    check("glitch_no_done", 32'(rx_cnt - rc), 32'd0);

    // tx_start while busy is dropped and tx_data is not re-latched
    loopback = 1'b1;
    rc = rx_cnt;
    tc = tx_cnt;
    start_tx(8'hA5);
    capture_tx(100, bits, doff, slen);
    check("ign_frame", 32'(bits), 32'hF4A);
    check("ign_done_off", 32'(doff), 32'd640);
    check("ign_tx_count", 32'(tx_cnt - tc), 32'd1);
    check("ign_rx_count", 32'(rx_cnt - rc), 32'd1);
    check("ign_rx_data", 32'(cap_data), 32'hA5);
    check("ign_busy_end", 32'(tx_busy), 32'd0);

    // Two stop bits: 11-bit frame
    two_stop = 1'b1;
    start_tx(8'h3C);
    capture_tx(-1, bits, doff, slen);
    check("2stop_frame", 32'(bits), 32'hE78);
    check("2stop_done_off", 32'(doff), 32'd704);
    check("2stop_rx_data", 32'(cap_data), 32'h3C);
    two_stop = 1'b0;

    // Back-to-back: start in the tx_done cycle is ignored, the next cycle is taken
    rc = rx_cnt;
    start_tx(8'h11);
    for (int i = 0; i < 1000; i++) begin
      if (tx_done) break;
      @(negedge main_clock);
    end
    check("b2b_first_done", 32'(tx_done), 32'd1);
    check("b2b_done_busy", 32'(tx_busy), 32'd0);
    tx_data  = 8'hC3;
    tx_start = 1'b1;
    @(negedge main_clock);
    check("b2b_same_cycle_ignored", 32'(tx_busy), 32'd0);
    @(negedge main_clock);
    tx_start = 1'b0;
    check("b2b_next_cycle_taken", 32'(tx_busy), 32'd1);
    capture_tx(-1, bits, doff, slen);
    check("b2b_frame", 32'(bits), 32'hF86);
    check("b2b_rx_count", 32'(rx_cnt - rc), 32'd2);
    check("b2b_rx_data", 32'(cap_data), 32'hC3);

    // Reset in the middle of DATA on both sides
    rc = rx_cnt;
    tc = tx_cnt;
    start_tx(8'h5A);
    idle(300);
    check("mid_tx_busy", 32'(tx_busy), 32'd1);
    check("mid_rx_busy", 32'(rx_busy), 32'd1);
    reset_all = 1'b1;
    #1;
    check("mrst_tx_serial", 32'(tx_serial), 32'd1);
    check("mrst_tx_busy", 32'(tx_busy), 32'd0);
    check("mrst_rx_busy", 32'(rx_busy), 32'd0);
    check("mrst_tx_done", 32'(tx_done), 32'd0);
    check("mrst_rx_done", 32'(rx_done), 32'd0);
    check("mrst_rx_data", 32'(rx_data), 32'd0);
    idle(5);
    reset_all = 1'b0;
    idle(800);
    check("mrst_no_tx_done", 32'(tx_cnt - tc), 32'd0);
    check("mrst_no_rx_done", 32'(rx_cnt - rc), 32'd0);
    start_tx(8'h5A);
    capture_tx(-1, bits, doff, slen);
    check("post_rst_frame", 32'(bits), 32'hEB4);
    check("post_rst_done_off", 32'(doff), 32'd640);
    check("post_rst_rx_count", 32'(rx_cnt - rc), 32'd1);
    check("post_rst_rx_data", 32'(cap_data), 32'h5A);
    check("post_rst_rx_fe", 32'(cap_fe), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
